// File: rtl/shift194_ctrl_pkg.sv
// shift194_ctrl_pkg: op codes, 194 mode encodings and FSM states for the 194 sequencer
package shift194_ctrl_pkg;
    localparam logic [2:0] OP_NOP   = 3'd0;
    localparam logic [2:0] OP_LOAD  = 3'd1;
    localparam logic [2:0] OP_SHR   = 3'd2;
    localparam logic [2:0] OP_SHL   = 3'd3;
    localparam logic [2:0] OP_ROR   = 3'd4;
    localparam logic [2:0] OP_ROL   = 3'd5;
    localparam logic [2:0] OP_JOHN  = 3'd6;
    localparam logic [2:0] OP_CLEAR = 3'd7;
    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_SHR  = 2'b01;
    localparam logic [1:0] MODE_SHL  = 2'b10;
    localparam logic [1:0] MODE_LOAD = 2'b11;
    typedef enum logic {ST_IDLE, ST_RUN} state_e;
    function automatic logic is_shift(input logic [2:0] op);
        return op inside {OP_SHR, OP_SHL, OP_ROR, OP_ROL, OP_JOHN};
    endfunction
    function automatic logic [1:0] shift_mode(input logic [2:0] op);
        return (op == OP_SHL || op == OP_ROL) ? MODE_SHL : MODE_SHR;
    endfunction
endpackage

// File: rtl/shift194_ctrl_if.sv
// shift194_ctrl_if: valid/ready command channel into the 194 sequencer
interface shift194_ctrl_if #(parameter int CNT_W = 4);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [2:0]       cmd_op;
    logic [3:0]       cmd_data;
    logic [CNT_W-1:0] cmd_cnt;
    logic             cmd_fill;
    modport master (output cmd_valid, cmd_op, cmd_data, cmd_cnt, cmd_fill, input cmd_ready);
    modport slave  (input cmd_valid, cmd_op, cmd_data, cmd_cnt, cmd_fill, output cmd_ready);
endinterface

// File: rtl/shift194_ctrl.sv
// shift194_ctrl: command sequencer driving the control, data and serial pins of a DM74LS194
module shift194_ctrl import shift194_ctrl_pkg::*; #(
    parameter int CNT_W = 4
) (
    input  logic            clk,
    input  logic            rst,
    shift194_ctrl_if.slave  cmd,
    input  logic [3:0]      q,
    output logic            CR,
    output logic            S1,
    output logic            S0,
    output logic            A,
    output logic            B,
    output logic            C,
    output logic            D,
    output logic            SL,
    output logic            SR,
    output logic            busy,
    output logic            done
);
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       op_q, op_d;
    logic             fill_q, fill_d;
    logic             cr_q, cr_d;
    logic [1:0]       mode_q, mode_d;
    logic [3:0]       abcd_q, abcd_d;
    logic             done_q, done_d;
    logic             accept, go_shift, run;
    logic             unused_q;
    assign unused_q      = ^q[2:1];
    assign run           = state_q == ST_RUN;
    assign cmd.cmd_ready = state_q == ST_IDLE && !rst;
    assign accept        = cmd.cmd_valid && cmd.cmd_ready;
    assign go_shift      = is_shift(cmd.cmd_op) && cmd.cmd_cnt != '0;
    assign CR            = cr_q;
    assign {S1, S0}      = mode_q;
    assign {A, B, C, D}  = abcd_q;
    assign busy          = run;
    assign done          = done_q;
    // serial inputs follow the live QA/QD so rotate and Johnson close the loop at the same edge
    always_comb begin
        SR = run && (op_q == OP_SHR ? fill_q : op_q == OP_ROR ? q[0] : op_q == OP_JOHN ? ~q[0] : 1'b0);
        SL = run && (op_q == OP_SHL ? fill_q : op_q == OP_ROL ? q[3] : 1'b0);
    end
    // next-state: latch a command when idle, count it down when running
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        fill_d  = fill_q;
        cr_d    = 1'b1;
        mode_d  = mode_q;
        abcd_d  = abcd_q;
        done_d  = 1'b0;
        if (run) begin
            if (cnt_q == CNT_W'(1)) begin
                state_d = ST_IDLE;
                mode_d  = MODE_HOLD;
                done_d  = 1'b1;
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
        end else if (accept) begin
            state_d = ST_RUN;
            op_d    = cmd.cmd_op;
            fill_d  = cmd.cmd_fill;
            cnt_d   = go_shift ? cmd.cmd_cnt : CNT_W'(1);
            mode_d  = cmd.cmd_op == OP_LOAD ? MODE_LOAD : go_shift ? shift_mode(cmd.cmd_op) : MODE_HOLD;
            abcd_d  = cmd.cmd_op == OP_LOAD ? cmd.cmd_data : abcd_q;
            cr_d    = cmd.cmd_op != OP_CLEAR;
        end
    end
    // state and registered 194 pins; reset holds the 194 cleared
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            op_q    <= OP_NOP;
            fill_q  <= 1'b0;
            cr_q    <= 1'b0;
            mode_q  <= MODE_HOLD;
            abcd_q  <= 4'b0000;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            fill_q  <= fill_d;
            cr_q    <= cr_d;
            mode_q  <= mode_d;
            abcd_q  <= abcd_d;
            done_q  <= done_d;
        end
    end
endmodule

// File: doc/shift194_ctrl.md
Name: shift194_ctrl

Overview:
Command sequencer that sits directly upstream of the DM74LS194 4-bit universal shift register and drives all of its control and data inputs (CR, S1, S0, A-D, SL, SR). It accepts one command at a time over a valid/ready handshake: load, clear, shift, rotate or Johnson-count for N clocks. It reads back QA-QD so that the rotate and Johnson modes can close the serial loop, then pulses done when the command completes. The sequencer and the 194 share one clock.

Parameters:
CNT_W, 4, width of the shift-count field; the maximum count per command is 2^CNT_W-1.

Ports:
clk  in  1  system clock, rising edge; same clock as the 194
rst  in  1  synchronous reset, active-high
cmd_valid  in  1  command present
cmd_ready  out  1  block can accept a command this cycle
cmd_op  in  3  operation code (see Behaviour)
cmd_data  in  4  parallel load value, {A,B,C,D} = cmd_data[3:0]
cmd_cnt  in  CNT_W  number of shift cycles
cmd_fill  in  1  serial fill bit for SHR/SHL
q  in  4  {QA,QB,QC,QD} fed back from the 194
CR  out  1  194 clear, active-low
S1, S0  out  1 each  194 mode: 00 hold, 01 shift right (QA<-SR), 10 shift left (QD<-SL), 11 load
A, B, C, D  out  1 each  194 parallel inputs
SL, SR  out  1 each  194 serial inputs
busy  out  1  command in progress
done  out  1  one-cycle completion pulse

Behaviour:
- Op codes:
  - 000 NOP
  - 001 LOAD
  - 010 SHR: SR = cmd_fill
  - 011 SHL: SL = cmd_fill
  - 100 ROR: SR = QD
  - 101 ROL: SL = QA
  - 110 JOHN: SR = ~QD
  - 111 CLEAR
- Reset (rst=1 at a clk edge) puts these values on the outputs after that edge:
  - CR=0, so the 194 is held cleared.
  - S1=S0=0, A-D=0, busy=0, done=0, cmd_ready=0.
  - Any command in flight is dropped and no done is issued.
  - The first cycle after rst deasserts gives CR=1 and cmd_ready=1.
- States: IDLE, RUN.
  - cmd_ready = (state==IDLE) && !rst.
  - busy = (state==RUN).
- Accept: cmd_valid && cmd_ready at edge t. The op, fill bit and count are latched at that edge.
- Registered outputs: CR, S1, S0, A-D, busy, done.
- Combinational outputs: SR and SL are muxed from the latched op, q and the latched fill bit.
  - This lets the 194 sample the current QD/QA at the same edge in the rotate and Johnson modes.
  - Outside the rotate/Johnson/fill cases, SR=SL=0.
- LOAD: at edge t, S1S0 becomes 11 and A-D become cmd_data. The 194 loads at edge t+1. At t+1 S1S0 returns to 00 and done=1 for one cycle.
- CLEAR: at edge t, CR becomes 0 for exactly one cycle. At t+1 CR returns to 1 and done=1.
- NOP, or any shift op with cmd_cnt=0: hold (S1S0=00) for one cycle, then done=1.
- Shift ops with cmd_cnt=N>0:
  - S1S0 is set at edge t to 01 (SHR/ROR/JOHN) or 10 (SHL/ROL).
  - A down-counter is loaded with N. The 194 shifts at edges t+1 .. t+N.
  - At edge t+N: S1S0 goes to 00, state goes to IDLE, done=1.
- Back-to-back: the cycle carrying done=1 already has cmd_ready=1. A command accepted in that cycle starts with no gap cycle.
- cmd_valid while busy is ignored; the master must hold it until accepted.
- A-D change only on LOAD. Their reset value is 0 and they retain their last value otherwise.

Decomposition:
- Shared package holds:
  - op-code constants OP_NOP .. OP_CLEAR
  - mode constants MODE_HOLD=2'b00, MODE_SHR=2'b01, MODE_SHL=2'b10, MODE_LOAD=2'b11
  - state encodings
- No sub-module: the FSM and counter are small.
- The bench instantiates the existing DM74LS194 as the downstream load, with QA-QD wired back to q.

Test Plan:
1. Reset then LOAD data=4'b1010 → S1S0=11 for one cycle, QA..QD=1010 one edge later, done pulses once, CR=1 throughout.
2. From QA..QD=1000, ROR cnt=4 → q sequence 0100, 0010, 0001, 1000; busy high for 4 cycles; done on the 4th edge.
3. From 0000, JOHN cnt=8 → q sequence 1000, 1100, 1110, 1111, 0111, 0011, 0001, 0000.
4. From 0000, SHL fill=1 cnt=2 → 0001 then 0011. Then CLEAR → CR low exactly one cycle, q=0000, done pulses.
5. rst asserted during the 2nd cycle of ROR cnt=5 → next edge CR=0, S1S0=00, busy=0, no done. After release, q=0000 and cmd_ready=1.
6. LOAD 0110 followed immediately by SHR fill=0 cnt=1, cmd_valid held high → SHR accepted in the done cycle, q = 0110 then 0011, two done pulses with no gap cycle.
